// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg
//   Shared definitions for the divider arbiter: FSM state encoding, the
//   watchdog margin above the operand width, and the round-robin grant
//   search used by the arbiter.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Largest requester count the grant search supports.
  localparam int MAX_REQ = 8;

  // The watchdog fires at W + WD_MARGIN cycles, comfortably past the
  // core's normal W+1 cycles spent in WAIT.
  localparam int WD_MARGIN = 4;

  // First requester with valid set, searching upward from ptr and wrapping
  // at num-1. Walking the offsets from high to low lets the nearest
  // requester overwrite the farther ones. Returns ptr when nothing is valid.
  function automatic int rr_grant(input logic [MAX_REQ-1:0] valid,
                                  input int ptr, input int num);
    int g;
    int idx;
    g = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < num) begin
        idx = (ptr + k) % num;
        if (valid[idx]) g = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/div_arbiter_div.sv
// div
//   Sequential radix-2 restoring divider core.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start           launch a division (honoured only while ready)
//     dvsr, dvnd      divisor, dividend (sampled on start)
//     ready           core idle and able to accept start
//     done_tick       one-cycle pulse, quo/rmd valid
//     quo, rmd        quotient and remainder
//   Latency: start in cycle s gives done_tick in cycle s+W+2.
module div #(
  parameter int W = 32,
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dvsr,
  input  logic [W-1:0] dvnd,
  output logic         ready,
  output logic         done_tick,
  output logic [W-1:0] quo,
  output logic [W-1:0] rmd
);

  typedef enum logic [1:0] {C_IDLE, C_OP, C_LAST, C_DONE} core_state_t;

  core_state_t  state, state_next;
  logic [W-1:0] rh, rh_next;
  logic [W-1:0] rl, rl_next;
  logic [W-1:0] d, d_next;
  logic [N-1:0] n, n_next;

  // Partial remainder shifted left by one with the next dividend bit.
  // rh < d holds throughout, so the difference always fits in W bits.
  logic [W:0] rem_shift;
  logic [W:0] rem_sub;
  logic       rem_ge;

  assign rem_shift = {rh, rl[W-1]};
  assign rem_sub   = rem_shift - {1'b0, d};
  assign rem_ge    = (rem_shift >= {1'b0, d});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= C_IDLE;
      rh    <= '0;
      rl    <= '0;
      d     <= '0;
      n     <= '0;
    end else begin
      state <= state_next;
      rh    <= rh_next;
      rl    <= rl_next;
      d     <= d_next;
      n     <= n_next;
    end
  end

  always_comb begin
    state_next = state;
    rh_next    = rh;
    rl_next    = rl;
    d_next     = d;
    n_next     = n;
    ready      = 1'b0;
    done_tick  = 1'b0;
    case (state)
      C_IDLE: begin
        ready = 1'b1;
        if (start) begin
          rh_next    = '0;
          rl_next    = dvnd;
          d_next     = dvsr;
          n_next     = N'(W);
          state_next = C_OP;
        end
      end
      C_OP: begin
        rh_next = rem_ge ? rem_sub[W-1:0] : rem_shift[W-1:0];
        rl_next = {rl[W-2:0], rem_ge};
        n_next  = n - 1'b1;
        if (n == N'(1)) state_next = C_LAST;
      end
      // Settle cycle; keeps the core's start-to-done latency at W+2.
      C_LAST: state_next = C_DONE;
      C_DONE: begin
        done_tick  = 1'b1;
        state_next = C_IDLE;
      end
      default: state_next = C_IDLE;
    endcase
  end

  assign quo = rl;
  assign rmd = rh;

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter
//   Round-robin scheduler sharing one sequential divider among R requesters.
//   Divide-by-zero is answered locally without launching the core.
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     req_valid[R]                 per-requester request
//     req_dividend/req_divisor     packed operands, requester i at [i*W +: W]
//     req_ready[R]                 one-hot accept strobe (IDLE only)
//     rsp_valid                    one-cycle result pulse
//     rsp_id, rsp_quotient,
//     rsp_remainder, rsp_dbz       result fields, held until the next result
//     busy                         high outside IDLE
//
//   state  | meaning
//   IDLE   | arbitrate; accept the round-robin winner
//   LAUNCH | pulse core start
//   WAIT   | wait for core done_tick, guarded by a watchdog
//   RESP   | present the result for one cycle
module div_arbiter #(
  parameter int W = 32,
  parameter int N = 6,
  parameter int R = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [R-1:0]                        req_valid,
  input  logic [R*W-1:0]                      req_dividend,
  input  logic [R*W-1:0]                      req_divisor,
  output logic [R-1:0]                        req_ready,
  output logic                                rsp_valid,
  output logic [((R > 1) ? $clog2(R) : 1)-1:0] rsp_id,
  output logic [W-1:0]                        rsp_quotient,
  output logic [W-1:0]                        rsp_remainder,
  output logic                                rsp_dbz,
  output logic                                busy
);

  import div_arbiter_pkg::*;

  localparam int IDW      = (R > 1) ? $clog2(R) : 1;
  localparam int WD_LIMIT = W + WD_MARGIN;

  arb_state_t     state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_inc;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   dvnd_q;
  logic [W-1:0]   dvsr_q;
  logic [N:0]     wd_cnt;
  logic           wd_expired;

  logic [W-1:0]   sel_dvnd;
  logic [W-1:0]   sel_dvsr;
  logic           sel_dbz;
  logic           accept;
  logic           core_start;
  logic           core_ready;
  logic           core_done;
  logic [W-1:0]   core_quo;
  logic [W-1:0]   core_rmd;

  assign grant      = IDW'(rr_grant(MAX_REQ'(req_valid), int'(rr_ptr), R));
  assign grant_inc  = (int'(grant) == R - 1) ? '0 : grant + IDW'(1);
  assign sel_dvnd   = req_dividend[int'(grant)*W +: W];
  assign sel_dvsr   = req_divisor[int'(grant)*W +: W];
  assign sel_dbz    = (sel_dvsr == '0);
  assign wd_expired = (wd_cnt == (N+1)'(WD_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // rst_n gates accept so that req_ready stays low throughout reset.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    core_start = 1'b0;
    busy       = 1'b1;
    req_ready  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rst_n && (|req_valid)) begin
          accept     = 1'b1;
          req_ready  = R'(1) << grant;
          state_next = sel_dbz ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        if (core_ready) begin
          core_start = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (core_done || wd_expired) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  // Response fields are only written on the transition into RESP so they
  // hold steady between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      id_q          <= '0;
      dvnd_q        <= '0;
      dvsr_q        <= '0;
      wd_cnt        <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= grant_inc;
        id_q   <= grant;
        dvnd_q <= sel_dvnd;
        dvsr_q <= sel_dvsr;
        if (sel_dbz) begin
          rsp_id        <= grant;
          rsp_quotient  <= '1;
          rsp_remainder <= sel_dvnd;
          rsp_dbz       <= 1'b1;
        end
      end
      if (state == LAUNCH) wd_cnt <= '0;
      if (state == WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (core_done) begin
          rsp_id        <= id_q;
          rsp_quotient  <= core_quo;
          rsp_remainder <= core_rmd;
          rsp_dbz       <= 1'b0;
        end else if (wd_expired) begin
          rsp_id        <= id_q;
          rsp_quotient  <= '1;
          rsp_remainder <= '1;
          rsp_dbz       <= 1'b1;
        end
      end
    end
  end

  div #(.W(W), .N(N)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .dvsr      (dvsr_q),
    .dvnd      (dvnd_q),
    .ready     (core_ready),
    .done_tick (core_done),
    .quo       (core_quo),
    .rmd       (core_rmd)
  );

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

  localparam int W = 32;
  localparam int N = 6;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [R-1:0]   req_valid = '0;
  logic [R*W-1:0] req_dividend = '0;
  logic [R*W-1:0] req_divisor = '0;
  logic [R-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_remainder;
  logic           rsp_dbz;
  logic           busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int start_seen = 0;

  div_arbiter #(.W(W), .N(N), .R(R)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dbz       (rsp_dbz),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.core_start) start_seen <= start_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[id*W +: W] = a;
    req_divisor[id*W +: W]  = b;
    req_valid[id]           = 1'b1;
  endtask

  // Returns the cycle in which some req_ready is high (-1 on timeout).
  task automatic wait_any_ready(output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (|req_ready) begin
        t = cyc;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid) begin
        t = cyc;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b0001;
    req_divisor[W-1:0] = 32'd3;
    tick();
    tick();
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready actual=%b required=0000", req_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({rsp_valid, busy, rsp_dbz, rsp_id} !== 5'b0 || rsp_quotient !== 0 || rsp_remainder !== 0)
      $display("FAIL reset_outputs actual=%b_%b_%b_%0d_%h_%h required=all_zero",
               rsp_valid, busy, rsp_dbz, rsp_id, rsp_quotient, rsp_remainder);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr !== 2'd0) $display("FAIL reset_rr_ptr actual=%0d required=0", dut.rr_ptr);
    else pass_cnt++;
    req_valid = '0;
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int ta, tr;
    set_req(0, 32'd100, 32'd7);
    wait_any_ready(ta);
    chk_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL single_grant actual=%b required=0001", req_ready);
    else pass_cnt++;
    tick();
    req_valid = '0;
    #1;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL single_busy actual=%b required=1", busy);
    else pass_cnt++;
    wait_rsp(tr);
    chk_cnt++;
    if (ta < 0 || tr !== ta + 36) $display("FAIL single_latency actual=%0d required=%0d", tr - ta, 36);
    else pass_cnt++;
    chk_cnt++;
    if (rsp_id !== 2'd0 || rsp_quotient !== 32'd14 || rsp_remainder !== 32'd2 || rsp_dbz !== 1'b0)
      $display("FAIL single_result actual=id%0d q%0d r%0d dbz%b required=id0 q14 r2 dbz0",
               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b0 || rsp_quotient !== 32'd14 || rsp_remainder !== 32'd2)
      $display("FAIL single_hold actual=v%b q%0d r%0d required=v0 q14 r2",
               rsp_valid, rsp_quotient, rsp_remainder);
    else pass_cnt++;
  endtask

  task automatic test_dbz();
    int ta, tr;
    start_seen = 0;
    set_req(3, 32'h1234, 32'd0);
    wait_any_ready(ta);
    chk_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL dbz_grant actual=%b required=1000", req_ready);
    else pass_cnt++;
    tick();
    req_valid = '0;
    wait_rsp(tr);
    chk_cnt++;
    if (ta < 0 || tr !== ta + 1) $display("FAIL dbz_latency actual=%0d required=1", tr - ta);
    else pass_cnt++;
    chk_cnt++;
    if (rsp_id !== 2'd3 || rsp_quotient !== 32'hFFFF_FFFF || rsp_remainder !== 32'h1234 || rsp_dbz !== 1'b1)
      $display("FAIL dbz_result actual=id%0d q%h r%h dbz%b required=id3 qffffffff r00001234 dbz1",
               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz);
    else pass_cnt++;
    tick();
    tick();
    chk_cnt++;
    if (start_seen !== 0) $display("FAIL dbz_no_start actual=%0d required=0", start_seen);
    else pass_cnt++;
  endtask

  task automatic test_all_four();
    logic [W-1:0] a [4] = '{32'd1000, 32'd77, 32'd9, 32'd5};
    logic [W-1:0] b [4] = '{32'd10, 32'd5, 32'd9, 32'd8};
    logic [W-1:0] q [4] = '{32'd100, 32'd15, 32'd1, 32'd0};
    logic [W-1:0] r [4] = '{32'd0, 32'd2, 32'd0, 32'd5};
    int ta, tr, tprev;
    tprev = -1;
    for (int i = 0; i < 4; i++) set_req(i, a[i], b[i]);
    for (int e = 0; e < 4; e++) begin
      wait_any_ready(ta);
      chk_cnt++;
      if (req_ready !== (4'b0001 << e)) $display("FAIL rr_grant%0d actual=%b required=%b", e, req_ready, 4'b0001 << e);
      else pass_cnt++;
      if (tprev >= 0) begin
        chk_cnt++;
        if (ta - tprev !== 37) $display("FAIL rr_throughput%0d actual=%0d required=37", e, ta - tprev);
        else pass_cnt++;
      end
      tprev = ta;
      tick();
      req_valid[e] = 1'b0;
      wait_rsp(tr);
      chk_cnt++;
      if (rsp_id !== 2'(e) || rsp_quotient !== q[e] || rsp_remainder !== r[e] || rsp_dbz !== 1'b0)
        $display("FAIL rr_result%0d actual=id%0d q%0d r%0d dbz%b required=id%0d q%0d r%0d dbz0",
                 e, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, e, q[e], r[e]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (dut.rr_ptr !== 2'd0) $display("FAIL rr_ptr_wrap actual=%0d required=0", dut.rr_ptr);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    int ta, tr;
    set_req(2, 32'd50, 32'd3);
    wait_any_ready(ta);
    chk_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL fair_first actual=%b required=0100", req_ready);
    else pass_cnt++;
    tick();
    tick();
    tick();
    set_req(0, 32'd81, 32'd9);
    wait_rsp(tr);
    chk_cnt++;
    if (rsp_id !== 2'd2 || rsp_quotient !== 32'd16 || rsp_remainder !== 32'd2)
      $display("FAIL fair_rsp_a actual=id%0d q%0d r%0d required=id2 q16 r2", rsp_id, rsp_quotient, rsp_remainder);
    else pass_cnt++;
    wait_any_ready(ta);
    chk_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL fair_second actual=%b required=0001", req_ready);
    else pass_cnt++;
    tick();
    req_valid[0] = 1'b0;
    wait_rsp(tr);
    chk_cnt++;
    if (rsp_id !== 2'd0 || rsp_quotient !== 32'd9 || rsp_remainder !== 32'd0)
      $display("FAIL fair_rsp_b actual=id%0d q%0d r%0d required=id0 q9 r0", rsp_id, rsp_quotient, rsp_remainder);
    else pass_cnt++;
    wait_any_ready(ta);
    chk_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL fair_third actual=%b required=0100", req_ready);
    else pass_cnt++;
    tick();
    req_valid[2] = 1'b0;
    wait_rsp(tr);
    chk_cnt++;
    if (rsp_id !== 2'd2 || rsp_quotient !== 32'd16 || rsp_remainder !== 32'd2)
      $display("FAIL fair_rsp_c actual=id%0d q%0d r%0d required=id2 q16 r2", rsp_id, rsp_quotient, rsp_remainder);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    int ta, tr;
    set_req(2, 32'd5, 32'hFFFF_FFFF);
    wait_any_ready(ta);
    tick();
    req_valid = '0;
    wait_rsp(tr);
    chk_cnt++;
    if (ta < 0 || rsp_id !== 2'd2 || rsp_quotient !== 32'd0 || rsp_remainder !== 32'd5 || rsp_dbz !== 1'b0)
      $display("FAIL ext_small actual=id%0d q%h r%h dbz%b required=id2 q00000000 r00000005 dbz0",
               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz);
    else pass_cnt++;
    set_req(1, 32'hFFFF_FFFF, 32'd1);
    wait_any_ready(ta);
    tick();
    req_valid = '0;
    wait_rsp(tr);
    chk_cnt++;
    if (ta < 0 || rsp_id !== 2'd1 || rsp_quotient !== 32'hFFFF_FFFF || rsp_remainder !== 32'd0 || rsp_dbz !== 1'b0)
      $display("FAIL ext_large actual=id%0d q%h r%h dbz%b required=id1 qffffffff r00000000 dbz0",
               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int ta, tr, seen;
    set_req(0, 32'd100, 32'd7);
    wait_any_ready(ta);
    tick();
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();
    rst_n = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk_cnt++;
    if ({rsp_valid, busy, rsp_dbz, rsp_id} !== 5'b0 || rsp_quotient !== 0 || rsp_remainder !== 0 || req_ready !== 4'b0)
      $display("FAIL midrst_outputs actual=%b_%b_%b_%0d_%h_%h_%b required=all_zero",
               rsp_valid, busy, rsp_dbz, rsp_id, rsp_quotient, rsp_remainder, req_ready);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr !== 2'd0) $display("FAIL midrst_rr_ptr actual=%0d required=0", dut.rr_ptr);
    else pass_cnt++;
    tick();
    req_valid = '0;
    #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk_cnt++;
    if (seen !== 0) $display("FAIL midrst_no_rsp actual=%0d required=0", seen);
    else pass_cnt++;
    set_req(1, 32'd1000, 32'd10);
    wait_any_ready(ta);
    tick();
    req_valid = '0;
    wait_rsp(tr);
    chk_cnt++;
    if (ta < 0 || tr !== ta + 36 || rsp_id !== 2'd1 || rsp_quotient !== 32'd100 || rsp_remainder !== 32'd0)
      $display("FAIL midrst_after actual=lat%0d id%0d q%0d r%0d required=lat36 id1 q100 r0",
               tr - ta, rsp_id, rsp_quotient, rsp_remainder);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dbz();
    test_all_four();
    test_fairness();
    test_extremes();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
